// File: rtl/pwm_capture.sv
// pwm_capture: Avalon-MM slave measuring PWM period and high time in clk cycles.
// Define PWM_CAPTURE_IRQ_EN to add the irq output, CTRL.IE and STATUS.IRQ_PEND.
module pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  input  logic        pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  state_t           state_reg;
  logic             en_reg;
  logic             sync1_reg, sync2_reg, prev_reg;
  logic [CNT_W-1:0] period_cnt_reg, high_cnt_reg;
  logic [CNT_W-1:0] period_reg, high_reg, high_shadow_reg;
  logic             valid_reg, ovf_reg, level_reg;
  logic [31:0]      readdata_reg;

  logic wr_en, rd_en, ctrl_wr, clr, en_next, stat_wr, ovf_clr;
  logic rise, measuring, capture, timeout;
  logic ctrl_ie, irq_pend;
  logic unused_bits;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign ctrl_wr   = wr_en && (address == 2'd0) && byteenable[0];
  assign clr       = ctrl_wr && writedata[1];
  assign en_next   = ctrl_wr ? writedata[0] : en_reg;
  assign stat_wr   = wr_en && (address == 2'd3) && byteenable[0];
  assign ovf_clr   = stat_wr && writedata[1];
  assign rise      = sync2_reg & ~prev_reg;
  // CLR and a dropped EN both pre-empt any capture or timeout this cycle
  assign measuring = en_reg && !clr && (state_reg == MEAS);
  assign capture   = measuring && rise;
  assign timeout   = measuring && !rise && (period_cnt_reg == TIMEOUT_CNT);

  assign unused_bits = ^{writedata[31:2], byteenable[3:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= pwm_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      en_reg          <= 1'b0;
      period_cnt_reg  <= '0;
      high_cnt_reg    <= '0;
      period_reg      <= '0;
      high_reg        <= '0;
      high_shadow_reg <= '0;
    end else begin
      if (ctrl_wr)
        en_reg <= writedata[0];
      if (clr) begin
        state_reg       <= en_next ? ARM : IDLE;
        period_cnt_reg  <= '0;
        high_cnt_reg    <= '0;
        period_reg      <= '0;
        high_reg        <= '0;
        high_shadow_reg <= '0;
      end else begin
        // HIGH is latched alongside a PERIOD read so the pair stays coherent
        if (rd_en && (address == 2'd1))
          high_shadow_reg <= high_reg;
        if (!en_reg) begin
          state_reg      <= IDLE;
          period_cnt_reg <= '0;
          high_cnt_reg   <= '0;
        end else begin
          case (state_reg)
            IDLE: state_reg <= ARM;
            ARM: begin
              if (rise) begin
                period_cnt_reg <= ONE_CNT;
                high_cnt_reg   <= ONE_CNT;
                state_reg      <= MEAS;
              end
            end
            MEAS: begin
              if (capture) begin
                period_reg     <= period_cnt_reg;
                high_reg       <= high_cnt_reg;
                period_cnt_reg <= ONE_CNT;
                high_cnt_reg   <= ONE_CNT;
              end else if (timeout) begin
                state_reg <= ARM;
              end else begin
                period_cnt_reg <= period_cnt_reg + ONE_CNT;
                if (sync2_reg)
                  high_cnt_reg <= high_cnt_reg + ONE_CNT;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      level_reg <= 1'b0;
    end else if (clr) begin
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      if (capture)
        valid_reg <= 1'b1;
      if (timeout) begin
        valid_reg <= 1'b0;
        ovf_reg   <= 1'b1;
        level_reg <= sync2_reg;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic ie_reg, irq_pend_reg, irq_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_reg       <= 1'b0;
      irq_pend_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (ctrl_wr)
        ie_reg <= writedata[2];
      // a new event beats a simultaneous write-1-to-clear
      if (clr)
        irq_pend_reg <= 1'b0;
      else if (capture || timeout)
        irq_pend_reg <= 1'b1;
      else if (stat_wr && writedata[3])
        irq_pend_reg <= 1'b0;
      irq_reg <= irq_pend_reg & ie_reg;
    end
  end

  assign ctrl_ie  = ie_reg;
  assign irq_pend = irq_pend_reg;
  assign irq      = irq_reg;
`else
  assign ctrl_ie  = 1'b0;
  assign irq_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= '0;
    end else if (rd_en) begin
      case (address)
        2'd0:    readdata_reg <= {29'd0, ctrl_ie, 1'b0, en_reg};
        2'd1:    readdata_reg <= 32'(period_reg);
        2'd2:    readdata_reg <= 32'(high_shadow_reg);
        default: readdata_reg <= {28'd0, irq_pend, level_reg, ovf_reg, valid_reg};
      endcase
    end
  end

  assign readdata = readdata_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed + randomized checks of pwm_capture against a waveform-level model.
// Exercises the PWM_CAPTURE_IRQ_EN path when that macro is defined.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        read = 1'b0;
  logic [3:0]  byteenable = 4'd0;
  logic [31:0] readdata;
  logic        pwm_in;
`ifdef PWM_CAPTURE_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // waveform generator controls: run a hi/lo pattern, or hold pwm_force
  bit pwm_run   = 1'b0;
  bit pwm_force = 1'b0;
  int pwm_hi    = 3;
  int pwm_lo    = 7;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .byteenable (byteenable),
    .readdata   (readdata),
    .pwm_in     (pwm_in)
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  // New hi/lo values take effect only at a period boundary, so every period is whole
  initial begin
    int ph, cur_hi, cur_lo;
    ph = 0; cur_hi = 3; cur_lo = 7;
    pwm_in = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!pwm_run) begin
        pwm_in = pwm_force;
        ph = 0;
      end else begin
        if (ph == 0) begin
          cur_hi = pwm_hi;
          cur_lo = pwm_lo;
        end
        pwm_in = (ph < cur_hi);
        ph = (ph + 1 == cur_hi + cur_lo) ? 0 : ph + 1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %s: observed 0x%0h", tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; byteenable = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_meas(input string tag, input int p, input int h, input logic [31:0] st);
    logic [31:0] rd;
    bus_read(2'd1, rd); check({tag, "_period"}, rd, p);
    bus_read(2'd2, rd); check({tag, "_high"}, rd, h);
    bus_read(2'd3, rd); check({tag, "_status"}, rd, st);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_ctrl;
    int hi, lo, old_p, exp_p, exp_h, g;
    bit seen;

    // reset, all registers read zero
    wait_cycles(3);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rd);
      check($sformatf("reset_addr%0d", a), rd, 32'd0);
    end

    // basic 3/7 measurement
    bus_write(2'd0, 32'h1, 4'hF);
    pwm_hi = 3; pwm_lo = 7; pwm_run = 1'b1;
    wait_cycles(40);
    expect_meas("basic", 10, 3, 32'h1);
    bus_read(2'd0, rd); check("ctrl_en", rd, 32'h1);

    // byte lane 0 disabled: EN survives; upper bits and IE/CLR-free write read back as EN only
    bus_write(2'd0, 32'h0, 4'b1110);
    bus_read(2'd0, rd); check("ctrl_byteen", rd, 32'h1);
    bus_write(2'd0, 32'hFFFF_FFF9, 4'hF);
    bus_read(2'd0, rd); check("ctrl_upper", rd, 32'h1);

    // switch to 25/75 while reading PERIOD/HIGH pairs with random gaps
    pwm_hi = 25; pwm_lo = 75;
    for (int k = 0; k < 12; k++) begin
      bus_read(2'd1, rd);
      exp_h = (rd == 32'd100) ? 25 : ((rd == 32'd10) ? 3 : -1);
      g = $urandom_range(0, 30);
      wait_cycles(g);
      bus_read(2'd2, rd);
      check($sformatf("coherent_pair%0d", k), rd, exp_h);
    end
    wait_cycles(250);
    expect_meas("duty25", 100, 25, 32'h1);

    // random periods, each held long enough for a full measurement
    old_p = 100;
    for (int k = 0; k < 6; k++) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 40);
      pwm_hi = hi; pwm_lo = lo;
      exp_p = hi + lo;
      wait_cycles(old_p + 2 * exp_p + 10);
      expect_meas($sformatf("rand%0d", k), exp_p, hi, 32'h1);
      old_p = exp_p;
    end

    // stuck high during a high phase: timeout with LEVEL=1, PERIOD/HIGH kept
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (pwm_in) seen = 1'b1;
    end
    pwm_force = 1'b1; pwm_run = 1'b0;
    wait_cycles(TIMEOUT + 30);
    expect_meas("stuck_high", old_p, hi, 32'h6);
    bus_write(2'd3, 32'h2, 4'hF);
    bus_read(2'd3, rd); check("ovf_w1c", rd, 32'h4);

    // one pulse then stuck low: timeout with LEVEL=0
    pwm_force = 1'b0; wait_cycles(4);
    pwm_force = 1'b1; wait_cycles(4);
    pwm_force = 1'b0;
    wait_cycles(TIMEOUT + 30);
    expect_meas("stuck_low", old_p, hi, 32'h2);

    // CLR coincident with a rise seen by the measuring FSM
    pwm_hi = 3; pwm_lo = 7; pwm_run = 1'b1;
    wait_cycles(40);
    expect_meas("pre_clr", 10, 3, 32'h3);
    pwm_run = 1'b0; pwm_force = 1'b0;
    wait_cycles(5);
    @(negedge clk);
    pwm_force = 1'b1;
    wait_cycles(2);
    bus_write(2'd0, 32'h3, 4'hF);
    expect_meas("clr_rise", 0, 0, 32'h0);
    bus_read(2'd0, rd); check("clr_ctrl", rd, 32'h1);
    pwm_force = 1'b0;
    wait_cycles(3);
    pwm_run = 1'b1;
    wait_cycles(40);
    expect_meas("post_clr", 10, 3, 32'h1);

`ifdef PWM_CAPTURE_IRQ_EN
    // IE=1, CLR drops any stale pending flag; irq follows each update
    bus_write(2'd0, 32'h7, 4'hF);
    bus_read(2'd0, rd); check("ctrl_ie", rd, 32'h5);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    check("irq_rise", seen, 1'b1);
    bus_write(2'd3, 32'h8, 4'hF);
    @(negedge clk);
    check("irq_cleared", irq, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    check("irq_again", seen, 1'b1);
    bus_read(2'd3, rd); check("status_pend", rd, 32'h9);
`else
    // without the IRQ option CTRL bit2 and STATUS bit3 stay zero
    bus_write(2'd0, 32'h5, 4'hF);
    bus_read(2'd0, rd); check("ctrl_no_ie", rd, 32'h1);
    bus_write(2'd3, 32'h8, 4'hF);
    bus_read(2'd3, rd); check("status_no_pend", rd, 32'h1);
`endif

    // reset in the middle of a measurement returns everything to zero
    wait_cycles(14);
    @(negedge clk); reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    check("reset_readdata", readdata, 32'd0);
    wait_cycles(30);
    exp_ctrl = 32'd0;
    bus_read(2'd0, rd); check("rst_ctrl", rd, exp_ctrl);
    expect_meas("rst_mid", 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
